// File: rtl/axil_reg_arbiter.sv
// axil_reg_arbiter: round-robin arbiter that shares one AXI4-Lite master port
// between NUM_REQ single-word requesters, one transaction outstanding at a time.
// Ports:
//   ACLK, ARESET                  clock, synchronous active-high reset
//   req_valid/req_write/req_addr/req_wdata   packed per-requester requests
//   req_ready                     one-hot grant pulse (combinational, IDLE only)
//   rsp_valid/rsp_id/rsp_rdata/rsp_resp      registered completion report
//   M_AXI_*                       AXI4-Lite master (AW, W, B, AR, R channels)
module axil_reg_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic                             rsp_valid,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic [ADDR_WIDTH-1:0]            M_AXI_AWADDR,
  output logic [2:0]                       M_AXI_AWPROT,
  output logic                             M_AXI_AWVALID,
  input  logic                             M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]            M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
  output logic                             M_AXI_WVALID,
  input  logic                             M_AXI_WREADY,
  input  logic [1:0]                       M_AXI_BRESP,
  input  logic                             M_AXI_BVALID,
  output logic                             M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic [2:0]                       M_AXI_ARPROT,
  output logic                             M_AXI_ARVALID,
  input  logic                             M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                       M_AXI_RRESP,
  input  logic                             M_AXI_RVALID,
  output logic                             M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AW_W = 3'd1;
  localparam logic [2:0] S_WR_B    = 3'd2;
  localparam logic [2:0] S_RD_AR   = 3'd3;
  localparam logic [2:0] S_RD_R    = 3'd4;

  logic [2:0]            r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr, r_gnt_id, w_gnt_id, w_rr_nxt;
  logic                  w_gnt_found, w_gnt_fire;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_wdata;
  logic                  w_gnt_write;
  logic                  w_aw_done, w_w_done;
  int unsigned           w_k;

  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_k         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_k = 32'(r_rr_ptr) + i;
      if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
      if (!w_gnt_found && req_valid[ID_W'(w_k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = ID_W'(w_k);
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    w_gnt_addr  = '0;
    w_gnt_wdata = '0;
    w_gnt_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == ID_W'(i)) begin
        w_gnt_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_gnt_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_gnt_write = req_write[i];
      end
    end
  end

  // The completion cycle is not a grant cycle: the next grant comes in the
  // IDLE cycle after rsp_valid, so a transaction spans at least 4 cycles.
  assign w_gnt_fire = (r_state == S_IDLE) && !r_rsp_valid && !ARESET && w_gnt_found;
  assign w_rr_nxt   = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (w_gnt_fire) req_ready[w_gnt_id] = 1'b1;
  end

  // A write channel is done once its valid has dropped or is handshaking now.
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_gnt_fire) w_state_nxt = w_gnt_write ? S_WR_AW_W : S_RD_AR;
      S_WR_AW_W: if (w_aw_done && w_w_done) w_state_nxt = S_WR_B;
      S_WR_B:    if (M_AXI_BVALID) w_state_nxt = S_IDLE;
      S_RD_AR:   if (M_AXI_ARREADY) w_state_nxt = S_RD_R;
      S_RD_R:    if (M_AXI_RVALID) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered AXI and response outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_fire) begin
            r_rr_ptr <= w_rr_nxt;
            r_gnt_id <= w_gnt_id;
            if (w_gnt_write) begin
              r_awaddr  <= w_gnt_addr;
              r_wdata   <= w_gnt_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_araddr  <= w_gnt_addr;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_WR_AW_W: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_bready <= 1'b1;
        end
        S_WR_B: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gnt_id;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= M_AXI_BRESP;
          end
        end
        S_RD_AR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_RD_R: begin
          if (M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gnt_id;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb_axil_reg_arbiter: directed stimulus against a 4-register AXI4-Lite slave
// model; expected grants and responses are queued at issue time and checked
// by an independent monitor on req_ready / rsp_valid.
module tb_axil_reg_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned AW      = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned IDW     = 2;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [NUM_REQ-1:0]    req_valid, req_ready, req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [DW-1:0]         rsp_rdata;
  logic [1:0]            rsp_resp;
  logic [AW-1:0]         M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]            M_AXI_AWPROT, M_AXI_ARPROT;
  logic                  M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DW-1:0]         M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]            M_AXI_WSTRB;
  logic [1:0]            M_AXI_BRESP, M_AXI_RRESP;
  logic                  M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic                  M_AXI_RVALID, M_AXI_RREADY;

  axil_reg_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model: 4 x 32-bit bank with wait-state knobs -----
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_inj = 2'b00, rresp_inj = 2'b00;
  logic [31:0] mem [4];
  logic s_aw_got, s_w_got, s_ar_got, s_bvalid, s_rvalid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [1:0] s_bresp, s_rresp;
  int s_aw_cnt, s_w_cnt, s_b_cnt, s_ar_cnt, s_r_cnt;
  logic w_aw_now, w_w_now, w_ar_now;
  logic [AW-1:0] w_waddr, w_raddr;
  logic [DW-1:0] w_wdat;

  assign M_AXI_AWREADY = M_AXI_AWVALID && !s_aw_got && (s_aw_cnt >= aw_dly);
  assign M_AXI_WREADY  = M_AXI_WVALID  && !s_w_got  && (s_w_cnt  >= w_dly);
  assign M_AXI_ARREADY = M_AXI_ARVALID && !s_ar_got && (s_ar_cnt >= ar_dly);
  assign M_AXI_BVALID  = s_bvalid;
  assign M_AXI_BRESP   = s_bresp;
  assign M_AXI_RVALID  = s_rvalid;
  assign M_AXI_RDATA   = s_rdata;
  assign M_AXI_RRESP   = s_rresp;
  assign w_aw_now = s_aw_got || (M_AXI_AWVALID && M_AXI_AWREADY);
  assign w_w_now  = s_w_got  || (M_AXI_WVALID  && M_AXI_WREADY);
  assign w_ar_now = s_ar_got || (M_AXI_ARVALID && M_AXI_ARREADY);
  assign w_waddr  = s_aw_got ? s_awaddr : M_AXI_AWADDR;
  assign w_wdat   = s_w_got  ? s_wdata  : M_AXI_WDATA;
  assign w_raddr  = s_ar_got ? s_araddr : M_AXI_ARADDR;

  // Bank contents survive reset so later reads show earlier writes.
  always @(posedge ACLK) begin
    if (ARESET) begin
      s_aw_got <= 0; s_w_got <= 0; s_ar_got <= 0; s_bvalid <= 0; s_rvalid <= 0;
      s_aw_cnt <= 0; s_w_cnt <= 0; s_b_cnt <= 0; s_ar_cnt <= 0; s_r_cnt <= 0;
      s_bresp <= 0; s_rresp <= 0; s_rdata <= 0; s_awaddr <= 0; s_araddr <= 0; s_wdata <= 0;
    end else begin
      if (M_AXI_AWVALID && !s_aw_got) begin
        if (M_AXI_AWREADY) begin s_aw_got <= 1; s_awaddr <= M_AXI_AWADDR; s_aw_cnt <= 0; end
        else s_aw_cnt <= s_aw_cnt + 1;
      end
      if (M_AXI_WVALID && !s_w_got) begin
        if (M_AXI_WREADY) begin s_w_got <= 1; s_wdata <= M_AXI_WDATA; s_w_cnt <= 0; end
        else s_w_cnt <= s_w_cnt + 1;
      end
      if (M_AXI_ARVALID && !s_ar_got) begin
        if (M_AXI_ARREADY) begin s_ar_got <= 1; s_araddr <= M_AXI_ARADDR; s_ar_cnt <= 0; end
        else s_ar_cnt <= s_ar_cnt + 1;
      end
      if (s_bvalid && M_AXI_BREADY) s_bvalid <= 0;
      else if (!s_bvalid && w_aw_now && w_w_now) begin
        if (s_b_cnt >= b_dly) begin
          s_bvalid <= 1; s_bresp <= bresp_inj; mem[w_waddr[3:2]] <= w_wdat;
          s_aw_got <= 0; s_w_got <= 0; s_b_cnt <= 0;
        end else s_b_cnt <= s_b_cnt + 1;
      end
      if (s_rvalid && M_AXI_RREADY) s_rvalid <= 0;
      else if (!s_rvalid && w_ar_now) begin
        if (s_r_cnt >= r_dly) begin
          s_rvalid <= 1; s_rdata <= mem[w_raddr[3:2]]; s_rresp <= rresp_inj;
          s_ar_got <= 0; s_r_cnt <= 0;
        end else s_r_cnt <= s_r_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ---------------------------------------------
  typedef struct { logic [IDW-1:0] id; logic [31:0] rdata; logic [1:0] resp; int lat; } rsp_t;
  typedef struct { logic [IDW-1:0] id; bit b2b; } gnt_t;
  rsp_t exp_rsp[$];
  gnt_t exp_gnt[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, last_gnt_cyc = 0, last_rsp_cyc = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_txn(input int id, input logic [31:0] rdata,
                                     input logic [1:0] resp, input int lat, input bit b2b);
    rsp_t r; gnt_t g;
    g.id = IDW'(id); g.b2b = b2b;
    r.id = IDW'(id); r.rdata = rdata; r.resp = resp; r.lat = lat;
    exp_gnt.push_back(g);
    exp_rsp.push_back(r);
  endfunction

  // Monitor: completions first, so a same-cycle grant sees the updated rsp cycle.
  always @(negedge ACLK) begin
    rsp_t r; gnt_t g;
    if (!ARESET) begin
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(r.id));
          check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
          check("rsp_resp", 64'(rsp_resp), 64'(r.resp));
          check("rsp_latency", 64'(cyc - last_gnt_cyc), 64'(r.lat));
        end
        last_rsp_cyc = cyc;
      end
      if (req_ready != '0) begin
        if (exp_gnt.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
        else begin
          g = exp_gnt.pop_front();
          check("grant_onehot", 64'(req_ready), 64'(4'b0001 << g.id));
          if (g.b2b) check("grant_after_rsp", 64'(cyc), 64'(last_rsp_cyc + 1));
        end
        last_gnt_cyc = cyc;
      end
    end
  end

  // AW/W valid-duration and payload-stability observer.
  int aw_hi = 0, w_hi = 0;
  bit unstable = 0;
  logic [AW-1:0] skew_addr = '0;
  logic [DW-1:0] skew_data = '0;
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (M_AXI_AWVALID) begin aw_hi++; if (M_AXI_AWADDR !== skew_addr) unstable = 1; end
      if (M_AXI_WVALID)  begin w_hi++;  if (M_AXI_WDATA  !== skew_data) unstable = 1; end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic req(input int id, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit got;
    got = 0;
    @(posedge ACLK); #1;
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[id*AW +: AW]  = addr;
    req_wdata[id*DW +: DW] = data;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge ACLK);
      if (req_ready[id]) got = 1;
      @(posedge ACLK); #1;
    end
    req_valid[id] = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL grant_timeout: requester %0d got no req_ready, required one within 300 cycles", id);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && exp_rsp.size() != 0; c++) @(negedge ACLK);
    check("drain_pending_rsp", 64'(exp_rsp.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_resp"}, 64'(rsp_resp), 64'd0);
    check({tag, "_axi_handshake"}, 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                        M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
    check({tag, "_awaddr"}, 64'(M_AXI_AWADDR), 64'd0);
    check({tag, "_araddr"}, 64'(M_AXI_ARADDR), 64'd0);
    check({tag, "_wdata"}, 64'(M_AXI_WDATA), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    exp_rsp.delete();
    exp_gnt.delete();
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs(tag);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    ARESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("por");
    check("awprot", 64'(M_AXI_AWPROT), 64'd0);
    check("arprot", 64'(M_AXI_ARPROT), 64'd0);
    check("wstrb", 64'(M_AXI_WSTRB), 64'hF);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Write 1..4 to 0x0..0xC then read back, all from requester 0, back to back.
    for (int i = 0; i < 4; i++) begin
      expect_txn(0, 32'h0, 2'b00, 3, i != 0);
      req(0, 1'b1, AW'(i * 4), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      expect_txn(0, 32'(i + 1), 2'b00, 3, 1'b1);
      req(0, 1'b0, AW'(i * 4), 32'h0);
    end
    drain();

    // Contention from rr_ptr=0: all four read, then requesters 1 and 3.
    do_reset("rst1");
    for (int i = 0; i < 4; i++) expect_txn(i, 32'(i + 1), 2'b00, 3, i != 0);
    fork
      req(0, 1'b0, 4'h0, 32'h0);
      req(1, 1'b0, 4'h4, 32'h0);
      req(2, 1'b0, 4'h8, 32'h0);
      req(3, 1'b0, 4'hC, 32'h0);
    join
    drain();
    expect_txn(1, 32'h2, 2'b00, 3, 1'b0);
    expect_txn(3, 32'h4, 2'b00, 3, 1'b1);
    fork
      req(1, 1'b0, 4'h4, 32'h0);
      req(3, 1'b0, 4'hC, 32'h0);
    join
    drain();

    // AW late by 3 cycles, W immediate.
    aw_dly = 3; w_dly = 0;
    skew_addr = 4'h8; skew_data = 32'hA5A5_0003; aw_hi = 0; w_hi = 0; unstable = 0;
    expect_txn(2, 32'h0, 2'b00, 6, 1'b0);
    req(2, 1'b1, 4'h8, 32'hA5A5_0003);
    drain();
    check("skew_aw_cycles", 64'(aw_hi), 64'd4);
    check("skew_w_cycles", 64'(w_hi), 64'd1);
    check("skew_payload_stable", 64'(unstable), 64'd0);

    // Mirror: W late by 3 cycles, AW immediate.
    aw_dly = 0; w_dly = 3;
    skew_addr = 4'h4; skew_data = 32'h5A5A_0002; aw_hi = 0; w_hi = 0; unstable = 0;
    expect_txn(3, 32'h0, 2'b00, 6, 1'b0);
    req(3, 1'b1, 4'h4, 32'h5A5A_0002);
    drain();
    check("mirror_aw_cycles", 64'(aw_hi), 64'd1);
    check("mirror_w_cycles", 64'(w_hi), 64'd4);
    check("mirror_payload_stable", 64'(unstable), 64'd0);

    // Both readys together: one cycle in WR_AW_W.
    w_dly = 0;
    skew_addr = 4'h0; skew_data = 32'h0F0F_0001; aw_hi = 0; w_hi = 0; unstable = 0;
    expect_txn(0, 32'h0, 2'b00, 3, 1'b0);
    req(0, 1'b1, 4'h0, 32'h0F0F_0001);
    drain();
    check("both_aw_cycles", 64'(aw_hi), 64'd1);
    check("both_w_cycles", 64'(w_hi), 64'd1);

    // Error responses pass through, then a normal request is still served.
    bresp_inj = 2'b10;
    expect_txn(1, 32'h0, 2'b10, 3, 1'b0);
    req(1, 1'b1, 4'hC, 32'hDEAD_BEEF);
    drain();
    bresp_inj = 2'b00; rresp_inj = 2'b11;
    expect_txn(1, 32'hDEAD_BEEF, 2'b11, 3, 1'b0);
    req(1, 1'b0, 4'hC, 32'h0);
    drain();
    rresp_inj = 2'b00;
    expect_txn(3, 32'h0F0F_0001, 2'b00, 3, 1'b0);
    req(3, 1'b0, 4'h0, 32'h0);
    drain();

    // BVALID 10 cycles late while requester 2 waits.
    b_dly = 10;
    expect_txn(0, 32'h0, 2'b00, 13, 1'b0);
    expect_txn(2, 32'h5A5A_0002, 2'b00, 3, 1'b1);
    fork
      req(0, 1'b1, 4'h0, 32'h1111_0000);
      begin repeat (3) @(posedge ACLK); req(2, 1'b0, 4'h4, 32'h0); end
    join
    drain();
    b_dly = 0;

    // Reset during RD_R: no completion, rr_ptr back to 0 (1 beats 3).
    r_dly = 5;
    begin
      gnt_t g;
      g.id = 2'd1; g.b2b = 1'b0;
      exp_gnt.push_back(g);
    end
    req(1, 1'b0, 4'h8, 32'h0);
    do_reset("rst_rd");
    r_dly = 0;
    expect_txn(1, 32'hA5A5_0003, 2'b00, 3, 1'b0);
    expect_txn(3, 32'hDEAD_BEEF, 2'b00, 3, 1'b1);
    fork
      req(1, 1'b0, 4'h8, 32'h0);
      req(3, 1'b0, 4'hC, 32'h0);
    join
    drain();
    repeat (5) @(negedge ACLK);
    check("leftover_grants", 64'(exp_gnt.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
